// File: rtl/sc_complex_fx_divider_if.sv
// Operand/result handshake bundle for sc_complex_fx_divider.
//   input_a_*/input_b_*  : dividend and divisor, signed Q format
//   input_stb/input_ack  : operand handshake (ack driven by the divider)
//   output_z_*           : quotient, divide-by-zero and saturation flags
//   output_z_stb/_ack    : result handshake (stb driven by the divider)
interface sc_complex_fx_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] input_a_real;
    logic [WIDTH-1:0] input_a_imag;
    logic [WIDTH-1:0] input_b_real;
    logic [WIDTH-1:0] input_b_imag;
    logic             input_stb;
    logic             input_ack;
    logic [WIDTH-1:0] output_z_real;
    logic [WIDTH-1:0] output_z_imag;
    logic             output_z_dbz;
    logic [1:0]       output_z_ovf;
    logic             output_z_stb;
    logic             output_z_ack;

    // Divider side
    modport slave (
        input  input_a_real, input_a_imag, input_b_real, input_b_imag,
        input  input_stb, output_z_ack,
        output input_ack, output_z_real, output_z_imag, output_z_dbz,
        output output_z_ovf, output_z_stb
    );

    // Producer/consumer side
    modport master (
        output input_a_real, input_a_imag, input_b_real, input_b_imag,
        output input_stb, output_z_ack,
        input  input_ack, output_z_real, output_z_imag, output_z_dbz,
        input  output_z_ovf, output_z_stb
    );
endinterface

// File: rtl/sc_complex_fx_divider.sv
// Fixed-point complex divider z = a / b, signed Q(WIDTH-FRAC).FRAC.
// Bit-serial restoring division of both quotient components in parallel.
//   clk, rst : clock, synchronous active-high reset
//   bus      : operand/result handshake bundle (slave modport)
module sc_complex_fx_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sc_complex_fx_divider_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;      // product width
    localparam int unsigned NW = 2 * WIDTH + 1;  // numerator/denominator width
    localparam int unsigned DW = 3 * WIDTH + 1;  // dividend/remainder width
    localparam int unsigned QW = WIDTH + 1;      // quotient magnitude width
    localparam int unsigned CW = $clog2(WIDTH + 2);

    localparam logic [QW-1:0]    POS_LIM = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic [QW-1:0]    NEG_LIM = {2'b01, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] Z_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Z_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MULT, SETUP, DIV, FIX, OUT} state_t;

    state_t state_q, state_d;
    logic   ack_q, ack_d;
    logic   z_stb_q, z_stb_d;
    logic   z_dbz_q, z_dbz_d;
    logic [1:0]       z_ovf_q, z_ovf_d;
    logic [WIDTH-1:0] z_r_q, z_r_d, z_i_q, z_i_d;

    logic signed [WIDTH-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
    logic signed [PW-1:0]    p_arbr_q, p_arbr_d, p_aibi_q, p_aibi_d;
    logic signed [PW-1:0]    p_aibr_q, p_aibr_d, p_arbi_q, p_arbi_d;
    logic signed [PW-1:0]    p_brbr_q, p_brbr_d, p_bibi_q, p_bibi_d;
    logic neg_r_q, neg_r_d, neg_i_q, neg_i_d, dbz_q, dbz_d;
    logic povf_r_q, povf_r_d, povf_i_q, povf_i_d;
    logic [DW-1:0] rem_r_q, rem_r_d, rem_i_q, rem_i_d, dsh_q, dsh_d;
    logic [QW-1:0] quo_r_q, quo_r_d, quo_i_q, quo_i_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic signed [NW-1:0] num_r, num_i;
    logic [NW-1:0] den, mag_r, mag_i;
    logic [DW-1:0] dvd_r, dvd_i;
    logic          ge_r, ge_i;
    logic [WIDTH:0] fix_r, fix_i;

    // Sign and saturation of one component; returns {saturated, value}
    function automatic logic [WIDTH:0] fix_comp(input logic neg, input logic povf,
                                                input logic [QW-1:0] mag);
        logic [WIDTH:0] res;
        if (neg) begin
            if (povf || (mag > NEG_LIM)) res = {1'b1, Z_MIN};
            else                         res = {1'b0, WIDTH'(-mag)};
        end else begin
            if (povf || (mag > POS_LIM)) res = {1'b1, Z_MAX};
            else                         res = {1'b0, mag[WIDTH-1:0]};
        end
        return res;
    endfunction

    // Next-state, datapath and output logic
    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        z_stb_d  = z_stb_q;
        z_dbz_d  = z_dbz_q;
        z_ovf_d  = z_ovf_q;
        z_r_d    = z_r_q;
        z_i_d    = z_i_q;
        ar_d     = ar_q;
        ai_d     = ai_q;
        br_d     = br_q;
        bi_d     = bi_q;
        p_arbr_d = p_arbr_q;
        p_aibi_d = p_aibi_q;
        p_aibr_d = p_aibr_q;
        p_arbi_d = p_arbi_q;
        p_brbr_d = p_brbr_q;
        p_bibi_d = p_bibi_q;
        neg_r_d  = neg_r_q;
        neg_i_d  = neg_i_q;
        dbz_d    = dbz_q;
        povf_r_d = povf_r_q;
        povf_i_d = povf_i_q;
        rem_r_d  = rem_r_q;
        rem_i_d  = rem_i_q;
        dsh_d    = dsh_q;
        quo_r_d  = quo_r_q;
        quo_i_d  = quo_i_q;
        cnt_d    = cnt_q;

        num_r = NW'(p_arbr_q) + NW'(p_aibi_q);
        num_i = NW'(p_aibr_q) - NW'(p_arbi_q);
        den   = NW'(p_brbr_q) + NW'(p_bibi_q);
        mag_r = num_r[NW-1] ? $unsigned(-num_r) : $unsigned(num_r);
        mag_i = num_i[NW-1] ? $unsigned(-num_i) : $unsigned(num_i);
        dvd_r = DW'(mag_r) << FRAC;
        dvd_i = DW'(mag_i) << FRAC;
        ge_r  = rem_r_q >= dsh_q;
        ge_i  = rem_i_q >= dsh_q;
        fix_r = fix_comp(neg_r_q, povf_r_q, quo_r_q);
        fix_i = fix_comp(neg_i_q, povf_i_q, quo_i_q);

        unique case (state_q)
            IDLE: begin
                ack_d = 1'b1;
                if (bus.input_stb && ack_q) begin
                    ack_d   = 1'b0;
                    ar_d    = bus.input_a_real;
                    ai_d    = bus.input_a_imag;
                    br_d    = bus.input_b_real;
                    bi_d    = bus.input_b_imag;
                    state_d = MULT;
                end
            end
            MULT: begin
                p_arbr_d = PW'(ar_q) * PW'(br_q);
                p_aibi_d = PW'(ai_q) * PW'(bi_q);
                p_aibr_d = PW'(ai_q) * PW'(br_q);
                p_arbi_d = PW'(ar_q) * PW'(bi_q);
                p_brbr_d = PW'(br_q) * PW'(br_q);
                p_bibi_d = PW'(bi_q) * PW'(bi_q);
                state_d  = SETUP;
            end
            SETUP: begin
                neg_r_d  = num_r[NW-1];
                neg_i_d  = num_i[NW-1];
                dbz_d    = (den == '0);
                // Quotient magnitude would not fit WIDTH+1 bits
                povf_r_d = dvd_r >= (DW'(den) << (WIDTH + 1));
                povf_i_d = dvd_i >= (DW'(den) << (WIDTH + 1));
                rem_r_d  = dvd_r;
                rem_i_d  = dvd_i;
                dsh_d    = DW'(den) << WIDTH;
                quo_r_d  = '0;
                quo_i_d  = '0;
                cnt_d    = '0;
                state_d  = DIV;
            end
            DIV: begin
                // Shared shifted divisor walks down one bit per cycle
                rem_r_d = ge_r ? (rem_r_q - dsh_q) : rem_r_q;
                rem_i_d = ge_i ? (rem_i_q - dsh_q) : rem_i_q;
                quo_r_d = {quo_r_q[QW-2:0], ge_r};
                quo_i_d = {quo_i_q[QW-2:0], ge_i};
                dsh_d   = dsh_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH)) state_d = FIX;
            end
            FIX: begin
                if (dbz_q) begin
                    z_r_d   = '0;
                    z_i_d   = '0;
                    z_ovf_d = 2'b00;
                end else begin
                    z_r_d   = fix_r[WIDTH-1:0];
                    z_i_d   = fix_i[WIDTH-1:0];
                    z_ovf_d = {fix_i[WIDTH], fix_r[WIDTH]};
                end
                z_dbz_d = dbz_q;
                z_stb_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (z_stb_q && bus.output_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            z_stb_q <= 1'b0;
            z_dbz_q <= 1'b0;
            z_ovf_q <= 2'b00;
            z_r_q   <= '0;
            z_i_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            z_stb_q <= z_stb_d;
            z_dbz_q <= z_dbz_d;
            z_ovf_q <= z_ovf_d;
            z_r_q   <= z_r_d;
            z_i_q   <= z_i_d;
        end
    end

    // Datapath registers; contents are don't-care outside an operation
    always_ff @(posedge clk) begin
        ar_q     <= ar_d;
        ai_q     <= ai_d;
        br_q     <= br_d;
        bi_q     <= bi_d;
        p_arbr_q <= p_arbr_d;
        p_aibi_q <= p_aibi_d;
        p_aibr_q <= p_aibr_d;
        p_arbi_q <= p_arbi_d;
        p_brbr_q <= p_brbr_d;
        p_bibi_q <= p_bibi_d;
        neg_r_q  <= neg_r_d;
        neg_i_q  <= neg_i_d;
        dbz_q    <= dbz_d;
        povf_r_q <= povf_r_d;
        povf_i_q <= povf_i_d;
        rem_r_q  <= rem_r_d;
        rem_i_q  <= rem_i_d;
        dsh_q    <= dsh_d;
        quo_r_q  <= quo_r_d;
        quo_i_q  <= quo_i_d;
        cnt_q    <= cnt_d;
    end

    assign bus.input_ack     = ack_q;
    assign bus.output_z_stb  = z_stb_q;
    assign bus.output_z_dbz  = z_dbz_q;
    assign bus.output_z_ovf  = z_ovf_q;
    assign bus.output_z_real = z_r_q;
    assign bus.output_z_imag = z_i_q;
endmodule
